// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter. A packet (bytes up to the one with last=1)
// holds the grant, and the hold is dropped if its owner stays idle for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 lock_active
);

  localparam int         CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [3:0] N4    = 4'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state;
  logic               armed;
  logic               last_q;
  logic [2:0]         rr_ptr;
  logic [CNT_W-1:0]   idle_cnt;

  logic [NUM_REQ-1:0] vld_rot;
  logic               rot_hit;
  logic [3:0]         rot_off;
  logic [3:0]         ptr_sum;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [NUM_REQ-1:0] sel_mask;
  logic [NUM_REQ-1:0] gid_mask;
  logic [7:0]         sel_byte;
  logic               sel_last;
  logic [2:0]         next_ptr;

  assign gid_mask = NUM_REQ'(1) << grant_id;
  assign sel_mask = NUM_REQ'(1) << sel_idx;
  assign sel_byte = 8'(req_data >> {sel_idx, 3'b000});
  assign sel_last = |(req_last & sel_mask);
  assign next_ptr = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

  // Rotate valids so rr_ptr sits at bit 0; the lowest set bit is then the round-robin winner.
  always_comb begin
    vld_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    rot_hit = 1'b0;
    rot_off = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        rot_hit = 1'b1;
        rot_off = 4'(k);
      end
    end
    ptr_sum = {1'b0, rr_ptr} + rot_off;
    if (ptr_sum >= N4) ptr_sum = ptr_sum - N4;
    if (lock_active) begin
      sel_found = |(req_valid & gid_mask);
      sel_idx   = grant_id;
    end else begin
      sel_found = rot_hit;
      sel_idx   = ptr_sum[2:0];
    end
  end

  // armed keeps req_ready quiet until the first clock edge after reset is released.
  assign req_ready = (armed && (state == IDLE) && sel_found) ? sel_mask : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= 3'd0;
      lock_active <= 1'b0;
      rr_ptr      <= 3'd0;
      idle_cnt    <= '0;
      last_q      <= 1'b0;
    end else begin
      armed    <= 1'b1;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (armed) begin
            if (sel_found) begin
              grant_id <= sel_idx;
              tx_data  <= sel_byte;
              last_q   <= sel_last;
              idle_cnt <= '0;
              tx_start <= 1'b1;
              state    <= ISSUE;
            end else if (lock_active) begin
              if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_active <= 1'b0;
                rr_ptr      <= next_ptr;
                idle_cnt    <= '0;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
            if (last_q) begin
              lock_active <= 1'b0;
              rr_ptr      <= next_ptr;
            end else begin
              lock_active <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a simple transmitter, and a per-cycle
// transaction-level reference model, plus directed packet/lock/timeout/reset scenarios.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic [2:0]     grant_id;
  logic           lock_active;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .lock_active(lock_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // requester side: each queue entry is {last, byte}
  logic [8:0] rq [N][$];
  int         pause [N];
  logic [N-1:0] rdy_seen = '0;
  bit         start_seen = 1'b0;
  bit         random_mode = 1'b0;

  // transmitter side
  int tx_dmin = 1, tx_dmax = 1, tx_hmin = 3, tx_hmax = 3;
  int tx_dly = 0, tx_hold = 0;

  // reference model: one byte in flight at most, plus lock/round-robin bookkeeping
  bit       m_armed, m_inflight, m_busy_seen, m_last, m_lock;
  int       m_since, m_gid, m_rr, m_idle;
  int       m_txd;

  // event logs for the directed checks
  int acc_cyc[$], acc_id[$], st_cyc[$], st_data[$], busy_fall[$];
  int lock_rise, lock_fall;
  bit prev_lock, prev_busy;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete(); st_cyc.delete(); st_data.delete(); busy_fall.delete();
    lock_rise = -1;
    lock_fall = -1;
  endtask

  task automatic model_reset();
    m_armed = 0; m_inflight = 0; m_busy_seen = 0; m_last = 0; m_lock = 0;
    m_since = 0; m_gid = 0; m_rr = 0; m_idle = 0; m_txd = 0;
  endtask

  task automatic drive_stimulus();
    for (int i = 0; i < N; i++) begin
      if (rdy_seen[i] && rq[i].size() > 0) begin
        if (random_mode && !rq[i][0][8] && $urandom_range(0, 3) == 0)
          pause[i] = $urandom_range(5, 25);
        void'(rq[i].pop_front());
      end else if (pause[i] > 0) begin
        pause[i]--;
      end
      if (random_mode && rq[i].size() == 0 && $urandom_range(0, 7) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
      end
      req_valid[i]      = (rq[i].size() > 0) && (pause[i] == 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      req_last[i]       = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
    if (start_seen) begin
      tx_dly  = $urandom_range(tx_dmin, tx_dmax);
      tx_hold = $urandom_range(tx_hmin, tx_hmax);
    end
    if (tx_dly > 0) begin
      tx_dly--;
      if (tx_dly == 0) tx_busy = 1'b1;
    end else if (tx_busy) begin
      if (tx_hold > 0) tx_hold--;
      if (tx_hold == 0) tx_busy = 1'b0;
    end
  endtask

  task automatic check_and_step();
    int pick, exp_rdy, id;
    bit exp_start;
    if (!rst) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_tx_data", int'(tx_data), 0);
      check("rst_grant_id", int'(grant_id), 0);
      check("rst_lock", int'(lock_active), 0);
      rdy_seen = '0;
      start_seen = 1'b0;
      return;
    end
    pick = -1;
    if (m_armed && !m_inflight) begin
      if (m_lock) begin
        if (req_valid[m_gid]) pick = m_gid;
      end else begin
        for (int k = 0; k < N; k++)
          if (pick < 0 && req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
      end
    end
    exp_rdy   = (pick >= 0) ? (1 << pick) : 0;
    exp_start = m_inflight && (m_since == 1);
    check("req_ready", int'(req_ready), exp_rdy);
    check("tx_start", int'(tx_start), int'(exp_start));
    check("tx_data", int'(tx_data), m_txd);
    check("grant_id", int'(grant_id), m_gid);
    check("lock_active", int'(lock_active), int'(m_lock));

    if (req_ready != '0) begin
      id = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
      acc_cyc.push_back(cyc);
      acc_id.push_back(id);
    end
    if (tx_start) begin
      st_cyc.push_back(cyc);
      st_data.push_back(int'(tx_data));
    end
    if (lock_active && !prev_lock) lock_rise = cyc;
    if (!lock_active && prev_lock) lock_fall = cyc;
    if (!tx_busy && prev_busy) busy_fall.push_back(cyc);
    prev_lock  = lock_active;
    prev_busy  = tx_busy;
    rdy_seen   = req_ready;
    start_seen = tx_start;

    if (m_inflight) begin
      if (m_since >= 2) begin
        if (!m_busy_seen) begin
          if (tx_busy) m_busy_seen = 1;
        end else if (!tx_busy) begin
          m_inflight = 0;
          if (m_last) begin
            m_lock = 0;
            m_rr   = (m_gid + 1) % N;
          end else begin
            m_lock = 1;
          end
        end
      end
      m_since++;
    end else if (m_armed) begin
      if (pick >= 0) begin
        m_inflight  = 1;
        m_since     = 1;
        m_busy_seen = 0;
        m_gid       = pick;
        m_txd       = int'(req_data[8*pick +: 8]);
        m_last      = req_last[pick];
        m_idle      = 0;
      end else if (m_lock) begin
        m_idle++;
        if (m_idle == TO) begin
          m_lock = 0;
          m_rr   = (m_gid + 1) % N;
          m_idle = 0;
        end
      end
    end
    m_armed = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_stimulus();
    @(negedge clk);
    check_and_step();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_accept(input int n, input int budget);
    int b;
    b = budget;
    while (acc_id.size() < n && b > 0) begin
      tick();
      b--;
    end
    check("wait_accept", acc_id.size(), n);
  endtask

  // Called just after a negedge: reset lands mid low-phase, away from any rising edge.
  task automatic assert_reset();
    #3;
    rst = 1'b0;
    tx_busy = 1'b0;
    tx_dly = 0;
    tx_hold = 0;
    rdy_seen = '0;
    start_seen = 1'b0;
    prev_lock = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      pause[i] = 0;
    end
    model_reset();
    #1;
    check("async_req_ready", int'(req_ready), 0);
    check("async_tx_start", int'(tx_start), 0);
    check("async_tx_data", int'(tx_data), 0);
    check("async_grant_id", int'(grant_id), 0);
    check("async_lock", int'(lock_active), 0);
  endtask

  task automatic release_reset();
    #2;
    rst = 1'b1;
    m_armed = 1;
    #1;
    check("ready_before_edge", int'(req_ready), 0);
  endtask

  task automatic full_reset();
    assert_reset();
    run(2);
    release_reset();
    clear_logs();
  endtask

  int rel_cyc;

  initial begin
    model_reset();
    clear_logs();
    for (int i = 0; i < N; i++) pause[i] = 0;
    full_reset();

    // single byte from requester 2
    rq[2].push_back({1'b1, 8'h48});
    run(20);
    check("single_count", acc_id.size(), 1);
    check("single_id", qget(acc_id, 0), 2);
    check("single_data", qget(st_data, 0), 8'h48);
    check("single_latency", qget(st_cyc, 0) - qget(acc_cyc, 0), 1);
    check("single_grant", int'(grant_id), 2);
    check("single_nolock", lock_rise, -1);

    // round robin, all four continuously valid with last=1
    full_reset();
    for (int i = 0; i < N; i++) begin
      rq[i].push_back({1'b1, 8'(8'h10 + i)});
      rq[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    run(100);
    check("rr_starts", st_cyc.size(), 8);
    for (int k = 0; k < 8; k++) check("rr_order", qget(acc_id, k), k % 4);

    // packet lock: req 1 sends HEL while others wait
    full_reset();
    rq[1].push_back({1'b0, 8'h48});
    rq[1].push_back({1'b0, 8'h45});
    rq[1].push_back({1'b1, 8'h4C});
    wait_accept(1, 10);
    rq[0].push_back({1'b1, 8'hA0});
    rq[2].push_back({1'b1, 8'hA2});
    rq[3].push_back({1'b1, 8'hA3});
    run(100);
    check("lock_id0", qget(acc_id, 0), 1);
    check("lock_id1", qget(acc_id, 1), 1);
    check("lock_id2", qget(acc_id, 2), 1);
    check("lock_id3", qget(acc_id, 3), 2);
    check("lock_id4", qget(acc_id, 4), 3);
    check("lock_id5", qget(acc_id, 5), 0);
    check("lock_d0", qget(st_data, 0), 8'h48);
    check("lock_d1", qget(st_data, 1), 8'h45);
    check("lock_d2", qget(st_data, 2), 8'h4C);
    check("lock_d3", qget(st_data, 3), 8'hA2);

    // lock timeout: req 3 leaves its packet open, req 0 waits
    full_reset();
    rq[3].push_back({1'b0, 8'h33});
    wait_accept(1, 10);
    rq[0].push_back({1'b1, 8'h30});
    run(60);
    check("to_id0", qget(acc_id, 0), 3);
    check("to_id1", qget(acc_id, 1), 0);
    check("to_lock_seen", int'(lock_rise >= 0), 1);
    check("to_release", lock_fall - lock_rise, 16);
    check("to_grant", qget(acc_cyc, 1) - lock_rise, 16);

    // long busy: second start exactly two cycles after busy falls
    full_reset();
    tx_dmin = 5; tx_dmax = 5; tx_hmin = 1600; tx_hmax = 1600;
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    run(3300);
    check("busy_starts", st_cyc.size(), 2);
    check("busy_gap", qget(st_cyc, 1) - qget(busy_fall, 0), 2);
    check("busy_d1", qget(st_data, 1), 8'h22);

    // reset in the middle of a locked packet
    full_reset();
    tx_dmin = 1; tx_dmax = 1; tx_hmin = 30; tx_hmax = 30;
    rq[1].push_back({1'b0, 8'h51});
    rq[1].push_back({1'b0, 8'h52});
    wait_accept(2, 80);
    run(4);
    check("mid_lock_held", int'(lock_active), 1);
    assert_reset();
    rq[0].push_back({1'b1, 8'h60});
    run(3);
    release_reset();
    clear_logs();
    rel_cyc = cyc;
    run(20);
    check("post_rst_id", qget(acc_id, 0), 0);
    check("post_rst_when", qget(acc_cyc, 0) - rel_cyc, 1);
    check("post_rst_data", qget(st_data, 0), 8'h60);

    // randomized traffic with pauses long enough to trip the lock timeout
    full_reset();
    tx_dmin = 1; tx_dmax = 3; tx_hmin = 1; tx_hmax = 12;
    random_mode = 1'b1;
    run(4000);
    random_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
